// File: rtl/ps2_key_arbiter.sv
// ps2_key_arbiter: syncs two PS2 held-key buses, decodes actions, makes press/repeat events, round-robin command channel
// Ports: i_clk, i_rst (sync, active-high); i_key_p1/i_key_p2 raw PS2-domain held codes (0 = none);
//   i_enable gates event generation; o_cmd_valid/i_cmd_ready handshake carrying o_cmd_player/o_cmd_action;
//   o_held_p1/o_held_p2 registered decoded action per player.
// Define PS2_KEY_ARB_REPEAT_EN for auto-repeat; otherwise exactly one event per press or action change.
module ps2_key_arbiter #(
  parameter int REPEAT_DELAY = 12500000,
  parameter int REPEAT_PERIOD = 2500000,
  parameter int CNT_W = 24
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_key_p1,
  input  logic [7:0] i_key_p2,
  input  logic       i_enable,
  input  logic       i_cmd_ready,
  output logic       o_cmd_valid,
  output logic       o_cmd_player,
  output logic [2:0] o_cmd_action,
  output logic [2:0] o_held_p1,
  output logic [2:0] o_held_p2
);
`ifdef PS2_KEY_ARB_REPEAT_EN
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
  localparam logic [CNT_W-1:0] DLY_T = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_T = CNT_W'(REPEAT_PERIOD - 1);
`else
  typedef enum logic {IDLE, HOLD} state_t;
`endif

  function automatic logic [2:0] decode(input logic p2, input logic [7:0] c);
    case ({p2, c})
      9'h075, 9'h11d: decode = 3'd1;
      9'h072, 9'h11b: decode = 3'd2;
      9'h06b, 9'h11c: decode = 3'd3;
      9'h074, 9'h123: decode = 3'd4;
      9'h05a, 9'h112: decode = 3'd5;
      9'h029, 9'h114: decode = 3'd6;
      default:        decode = 3'd0;
    endcase
  endfunction

  logic [1:0] slot_v, grant;
  logic [2:0] slot_a [2];
  logic [2:0] held [2];
  logic rr, load;

  for (genvar g = 0; g < 2; g++) begin : gen_player
    logic [7:0] k, s1, s2, st, acc_q, acc;
    logic [2:0] a, hd, sa;
    logic sv, emit;
    state_t s, s_n;
    assign k = (g == 0) ? i_key_p1 : i_key_p2;
    // a code is trusted only once two consecutive synchronised samples agree
    assign acc = (s2 == st) ? s2 : acc_q;
    assign a = decode(g == 1, acc);
`ifdef PS2_KEY_ARB_REPEAT_EN
    logic [CNT_W-1:0] cnt, cnt_n;
    logic term;
    assign term = (s == DELAY) ? cnt == DLY_T : cnt == PER_T;
    // a due repeat waits at terminal count while the slot is still occupied
    always_comb begin
      s_n = s;
      cnt_n = cnt + 1'b1;
      emit = 1'b0;
      if (!i_enable || a == '0) begin
        s_n = IDLE;
        cnt_n = '0;
      end else if (s == IDLE || a != hd) begin
        s_n = DELAY;
        cnt_n = '0;
        emit = 1'b1;
      end else if (term) begin
        emit = !sv;
        s_n = sv ? s : REPEAT;
        cnt_n = sv ? cnt : '0;
      end
    end
    always_ff @(posedge i_clk)
      if (i_rst) cnt <= '0;
      else cnt <= cnt_n;
`else
    always_comb begin
      s_n = s;
      emit = 1'b0;
      if (!i_enable || a == '0) s_n = IDLE;
      else if (s == IDLE || a != hd) begin
        s_n = HOLD;
        emit = 1'b1;
      end
    end
`endif
    always_ff @(posedge i_clk)
      if (i_rst) begin
        {s1, s2, st, acc_q} <= '0;
        hd <= '0;
        sa <= '0;
        sv <= 1'b0;
        s <= IDLE;
      end else begin
        s1 <= k;
        s2 <= s1;
        st <= s2;
        acc_q <= acc;
        hd <= a;
        s <= s_n;
        // a new event always wins over the grant clearing the slot
        sv <= emit || (sv && !grant[g] && i_enable && a != '0);
        if (emit) sa <= a;
      end
    assign slot_v[g] = sv;
    assign slot_a[g] = sa;
    assign held[g] = hd;
  end

  assign load = !o_cmd_valid || i_cmd_ready;
  assign grant[0] = load && slot_v[0] && (!slot_v[1] || !rr);
  assign grant[1] = load && slot_v[1] && (!slot_v[0] || rr);

  always_ff @(posedge i_clk)
    if (i_rst) {o_cmd_valid, o_cmd_player, o_cmd_action, rr} <= '0;
    else if (load) begin
      o_cmd_valid <= |grant;
      if (|grant) begin
        o_cmd_player <= grant[1];
        o_cmd_action <= grant[1] ? slot_a[1] : slot_a[0];
        rr <= grant[0];
      end
    end

  assign o_held_p1 = held[0];
  assign o_held_p2 = held[1];
endmodule

// File: tb/tb_ps2_key_arbiter.sv
// tb_ps2_key_arbiter: directed stimulus, timestamp-based reference model compared every cycle, plus literal checks
module tb_ps2_key_arbiter;
  localparam int D = 8;
  localparam int P = 4;
`ifdef PS2_KEY_ARB_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, en, rdy;
  logic [7:0] k1, k2;
  logic valid, player;
  logic [2:0] action, held1, held2;
  int errors = 0;
  int checks = 0;

  ps2_key_arbiter #(.REPEAT_DELAY(D), .REPEAT_PERIOD(P), .CNT_W(24)) dut (
    .i_clk(clk), .i_rst(rst), .i_key_p1(k1), .i_key_p2(k2), .i_enable(en),
    .i_cmd_ready(rdy), .o_cmd_valid(valid), .o_cmd_player(player),
    .o_cmd_action(action), .o_held_p1(held1), .o_held_p2(held2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s at %0t: got %0d want %0d", nm, $time, got, want);
    end
  endtask

  function automatic logic [2:0] dec(input int p, input logic [7:0] c);
    logic [7:0] t [6];
    if (p == 0) t = '{8'h75, 8'h72, 8'h6b, 8'h74, 8'h5a, 8'h29};
    else t = '{8'h1d, 8'h1b, 8'h1c, 8'h23, 8'h12, 8'h14};
    for (int i = 0; i < 6; i++) if (c == t[i]) return 3'(i + 1);
    return 3'd0;
  endfunction

  // reference model: key samples history, accepted code, press timestamps and next-repeat due times
  logic [7:0] hist [2][3];
  logic [7:0] macc [2];
  logic [2:0] mheld [2];
  logic [2:0] msa [2];
  bit mact [2];
  bit msv [2];
  int due [2];
  bit mv, mp, mrr, started;
  logic [2:0] ma;
  int cyc;

  always @(posedge clk) begin : mdl
    logic [7:0] kin [2];
    logic [2:0] a [2];
    bit g [2];
    bit sv_pre [2];
    bit ld;
    kin[0] = k1;
    kin[1] = k2;
    if (rst) begin
      started = 1'b1;
      for (int p = 0; p < 2; p++) begin
        for (int j = 0; j < 3; j++) hist[p][j] = 8'h00;
        macc[p] = 8'h00;
        mheld[p] = 3'd0;
        msa[p] = 3'd0;
        mact[p] = 1'b0;
        msv[p] = 1'b0;
        due[p] = 0;
      end
      {mv, mp, mrr} = 3'b000;
      ma = 3'd0;
      cyc = 0;
    end else begin
      cyc++;
      for (int p = 0; p < 2; p++) begin
        if (hist[p][1] == hist[p][2]) macc[p] = hist[p][1];
        a[p] = dec(p, macc[p]);
        hist[p][2] = hist[p][1];
        hist[p][1] = hist[p][0];
        hist[p][0] = kin[p];
        sv_pre[p] = msv[p];
      end
      ld = !mv || rdy;
      g[0] = ld && msv[0] && (!msv[1] || !mrr);
      g[1] = ld && msv[1] && !g[0];
      if (ld) begin
        mv = g[0] || g[1];
        if (mv) begin
          mp = g[1];
          ma = g[1] ? msa[1] : msa[0];
          mrr = g[0];
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (g[p]) msv[p] = 1'b0;
        if (!en || a[p] == 3'd0) begin
          mact[p] = 1'b0;
          msv[p] = 1'b0;
        end else if (!mact[p] || a[p] != mheld[p]) begin
          mact[p] = 1'b1;
          due[p] = cyc + D;
          msv[p] = 1'b1;
          msa[p] = a[p];
        end else if (REP_EN && cyc >= due[p] && !sv_pre[p]) begin
          msv[p] = 1'b1;
          msa[p] = a[p];
          due[p] = cyc + P;
        end
        mheld[p] = a[p];
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("valid", valid, mv);
      if (mv) begin
        chk("player", player, mp);
        chk("action", action, ma);
      end
      chk("held1", held1, mheld[0]);
      chk("held2", held2, mheld[1]);
    end
  end

  task automatic w(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int n;
    int last;
    rst = 1'b1; en = 1'b1; rdy = 1'b1; k1 = 8'h00; k2 = 8'h00;
    w(3);
    rst = 1'b0;
    chk("rst_valid", valid, 0);
    chk("rst_held1", held1, 0);
    chk("rst_held2", held2, 0);
    // press latency and repeat cadence
    k1 = 8'h75;
    w(4); chk("lat_not_yet", valid, 0);
    w(1); chk("lat_valid", valid, 1); chk("lat_player", player, 0); chk("lat_action", action, 1);
    chk("lat_held1", held1, 1);
    w(7); chk("rep_gap", valid, 0);
    w(1); chk("rep1_valid", valid, REP_EN);
    w(4); chk("rep2_valid", valid, REP_EN);
    k1 = 8'h00; w(10);
    // reset mid-DELAY with a held key
    k1 = 8'h72; w(7);
    rst = 1'b1; w(1); rst = 1'b0;
    chk("mid_rst_valid", valid, 0); chk("mid_rst_held1", held1, 0);
    w(4); chk("re_emit_early", valid, 0);
    w(1); chk("re_emit_valid", valid, 1); chk("re_emit_action", action, 2);
    k1 = 8'h00; w(8);
    rst = 1'b1; w(1); rst = 1'b0;
    // simultaneous presses, pointer on player 1 after reset
    k1 = 8'h6b; k2 = 8'h23;
    w(5); chk("rr_first_player", player, 0); chk("rr_first_action", action, 3);
    w(1); chk("rr_second_player", player, 1); chk("rr_second_action", action, 4);
    k1 = 8'h00; k2 = 8'h00; w(8);
    // leave the pointer on player 2, then press both again
    k1 = 8'h74; w(5); k1 = 8'h00; w(10);
    k1 = 8'h72; k2 = 8'h1b;
    w(5); chk("rr2_first_player", player, 1); chk("rr2_first_action", action, 2);
    w(1); chk("rr2_second_player", player, 0); chk("rr2_second_action", action, 2);
    k1 = 8'h00; k2 = 8'h00; w(10);
    // consumer stalls for 20 cycles
    rdy = 1'b0; k1 = 8'h75;
    w(5); chk("stall_valid", valid, 1); chk("stall_action", action, 1);
    w(15); chk("stall_hold_valid", valid, 1); chk("stall_hold_action", action, 1);
    rdy = 1'b1; w(12);
    k1 = 8'h00; w(10);
    // glitches never become events
    k1 = 8'h5a; w(8);
    k1 = 8'h5b; w(1); k1 = 8'h5a; w(8); chk("glitch_held", held1, 5);
    k1 = 8'h00; w(1); k1 = 8'h5a; w(8); chk("dropout_held", held1, 5);
    k1 = 8'h00; w(8);
    // release empties the pending slot while the output is stalled
    rdy = 1'b0; k1 = 8'h75; w(8);
    k1 = 8'h72; w(6);
    k1 = 8'h00; w(6);
    chk("rel_valid", valid, 1); chk("rel_action", action, 1);
    rdy = 1'b1; w(1); chk("rel_drained", valid, 0);
    w(3); chk("rel_no_more", valid, 0);
    // enable low suppresses events; raising it is a fresh press
    en = 1'b0; k1 = 8'h75; w(10);
    chk("dis_valid", valid, 0); chk("dis_held", held1, 1);
    en = 1'b1; w(2); chk("en_valid", valid, 1); chk("en_action", action, 1);
    k1 = 8'h00; w(10);
    // long holds: one command each when auto-repeat is absent
    n = 0; last = 0; k1 = 8'h29;
    repeat (100) begin
      @(negedge clk);
      if (valid && rdy) begin n++; last = action; end
    end
    if (!REP_EN) begin chk("hold29_count", n, 1); chk("hold29_action", last, 6); end
    n = 0; k1 = 8'h74;
    repeat (30) begin
      @(negedge clk);
      if (valid && rdy) begin n++; last = action; end
    end
    if (!REP_EN) begin chk("hold74_count", n, 1); chk("hold74_action", last, 4); end
    k1 = 8'h00; w(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
